// File: rtl/i281_loader_pkg.sv
// Shared types and constants for the i281 instruction-memory program loader.
package i281_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HI_BYTE = 3'd1,
    LO_BYTE = 3'd2,
    WRITE   = 3'd3,
    CHECK   = 3'd4
  } state_e;

  localparam int IMEM_WORDS = 32;
  localparam int BANK_WORDS = 16;
  localparam int LEN_W      = 6;

  // A requested length above the IMEM size is clamped to a full-memory load.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(IMEM_WORDS)) ? LEN_W'(IMEM_WORDS) : len;
  endfunction

endpackage

// File: rtl/imem_bank_decode.sv
// Splits a 5-bit IMEM word address into a bank strobe and an in-bank select;
// the select keeps the last written index between writes.
module imem_bank_decode
  import i281_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          write_i,
  output logic [$clog2(BANK_WORDS)-1:0] sel_o,
  output logic                          we_low_o,
  output logic                          we_high_o
);

  localparam int SEL_W = $clog2(BANK_WORDS);

  logic [SEL_W-1:0] sel_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel_q <= '0;
    end else if (write_i) begin
      sel_q <= addr_i[SEL_W-1:0];
    end
  end

  assign sel_o     = write_i ? addr_i[SEL_W-1:0] : sel_q;
  assign we_low_o  = write_i & ~addr_i[ADDR_WIDTH-1];
  assign we_high_o = write_i &  addr_i[ADDR_WIDTH-1];

endmodule

// File: rtl/imem_program_loader.sv
// Byte-stream to IMEM loader: assembles big-endian words, writes them across
// both IMEM banks and checks a trailing XOR checksum.
//
// Stream handshake: a byte moves on a rising edge only when BYTE_VALID and
// BYTE_READY are both high; BYTE_READY depends on state alone, BYTE_IN is
// ignored in any other cycle, and the host may drop BYTE_VALID at any time.
module imem_program_loader
  import i281_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 16,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  LOAD_START,
  input  logic [ADDR_WIDTH-1:0] LOAD_BASE,
  input  logic [ADDR_WIDTH:0]   LOAD_LENGTH,
  input  logic [BYTE_WIDTH-1:0] BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic [WORD_WIDTH-1:0] IMEM_INPUT,
  output logic [3:0]            WRITE_SELECT,
  output logic                  WRITE_ENABLE_LOW,
  output logic                  WRITE_ENABLE_HIGH,
  output logic                  BUSY,
  output logic                  LOAD_DONE,
  output logic                  CKSUM_ERR,
  output logic [2:0]            DEBUG_STATE
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic [BYTE_WIDTH-1:0] chk_q;
  logic [WORD_WIDTH-1:0] hold_q;
  logic [WORD_WIDTH-1:0] last_q;
  logic                  done_q;
  logic                  err_q;

  logic ready;
  logic busy;
  logic write_pulse;
  logic xfer;
  logic start_acc;

  assign xfer      = BYTE_VALID & ready;
  assign start_acc = (state_q == IDLE) & LOAD_START & (LOAD_LENGTH != '0);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = HI_BYTE;
      HI_BYTE: if (xfer) state_d = LO_BYTE;
      LO_BYTE: if (xfer) state_d = WRITE;
      WRITE:   state_d = (rem_q == (ADDR_WIDTH+1)'(1)) ? CHECK : HI_BYTE;
      CHECK:   if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    ready       = (state_q == HI_BYTE) || (state_q == LO_BYTE) || (state_q == CHECK);
    write_pulse = (state_q == WRITE);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      addr_q <= '0;
      rem_q  <= '0;
      chk_q  <= '0;
      hold_q <= '0;
      last_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_acc) begin
        addr_q <= LOAD_BASE;
        rem_q  <= sat_len(LOAD_LENGTH);
        chk_q  <= '0;
        err_q  <= 1'b0;
      end
      case (state_q)
        HI_BYTE: if (xfer) begin
          hold_q[WORD_WIDTH-1:BYTE_WIDTH] <= BYTE_IN;
          chk_q                           <= chk_q ^ BYTE_IN;
        end
        LO_BYTE: if (xfer) begin
          hold_q[BYTE_WIDTH-1:0] <= BYTE_IN;
          chk_q                  <= chk_q ^ BYTE_IN;
        end
        WRITE: begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          rem_q  <= rem_q - (ADDR_WIDTH+1)'(1);
          last_q <= hold_q;
        end
        CHECK: if (xfer) begin
          // Data bytes XOR checksum byte must cancel to zero.
          err_q  <= (chk_q ^ BYTE_IN) != '0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  imem_bank_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank_decode (
    .clk_i     (CLOCK),
    .rst_ni    (RESET_N),
    .addr_i    (addr_q),
    .write_i   (write_pulse),
    .sel_o     (WRITE_SELECT),
    .we_low_o  (WRITE_ENABLE_LOW),
    .we_high_o (WRITE_ENABLE_HIGH)
  );

  assign IMEM_INPUT  = write_pulse ? hold_q : last_q;
  assign BYTE_READY  = ready;
  assign BUSY        = busy;
  assign LOAD_DONE   = done_q;
  assign CKSUM_ERR   = err_q;
  assign DEBUG_STATE = state_q;

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Upstream feeder for the i281 instruction memory: accepts a byte stream from a host link over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Drives the write port of the two 16-word IMEM banks (low bank = addresses 0-15, high bank = 16-31).
- Verifies a trailing XOR checksum and reports done/error.
- Sits between the host receive logic and the IMEM low/high register files.

Parameters:
- ADDR_WIDTH, 5, word address width across both banks (bit 4 = bank select).
- WORD_WIDTH, 16, instruction word width.
- BYTE_WIDTH, 8, stream byte width; WORD_WIDTH = 2*BYTE_WIDTH is required.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous active-low reset.
- LOAD_START  in  1  one-cycle request to begin a load; sampled only in IDLE.
- LOAD_BASE  in  5  first word address, captured on accepted start.
- LOAD_LENGTH  in  6  word count, captured on accepted start; 0 = reject start; values above 32 saturate to 32.
- BYTE_IN  in  8  stream data.
- BYTE_VALID  in  1  stream data valid.
- BYTE_READY  out  1  loader can accept a byte this cycle.
- IMEM_INPUT  out  16  assembled word to IMEM.
- WRITE_SELECT  out  4  word index within the selected bank (addr[3:0]).
- WRITE_ENABLE_LOW  out  1  write strobe to the low bank (addr[4]=0).
- WRITE_ENABLE_HIGH  out  1  write strobe to the high bank (addr[4]=1).
- BUSY  out  1  high in every state except IDLE.
- LOAD_DONE  out  1  one-cycle pulse when the checksum byte is consumed.
- CKSUM_ERR  out  1  sticky; valid from the LOAD_DONE cycle; cleared on the next accepted start or reset.

Behaviour:
- A byte transfers on a rising edge only when BYTE_VALID and BYTE_READY are both high. BYTE_IN is ignored otherwise.
- BYTE_READY is combinational from state: it is high only in HI_BYTE, LO_BYTE and CHECK.
- Reset (RESET_N=0 at an edge) forces:
  - state IDLE; all outputs 0;
  - address counter, remaining count, checksum and holding register all 0.
- Reset mid-load abandons the transfer. Words already written stay in IMEM. No LOAD_DONE is produced.
- IDLE:
  - LOAD_START=1 and LOAD_LENGTH!=0: capture base, capture saturated length, clear checksum, clear CKSUM_ERR, go to HI_BYTE.
  - LOAD_LENGTH=0: no state change, no flag change.
- HI_BYTE: on transfer, hold[15:8]=byte, chk^=byte, go to LO_BYTE.
- LO_BYTE: on transfer, hold[7:0]=byte, chk^=byte, go to WRITE.
- WRITE (exactly one cycle, no byte accepted):
  - IMEM_INPUT=hold; WRITE_SELECT=addr[3:0].
  - Exactly one bank strobe asserted, chosen by addr[4].
  - Next edge: addr=addr+1 mod 32 (31 wraps to 0); remaining=remaining-1.
  - If remaining was 1, go to CHECK; otherwise go to HI_BYTE.
- Outside WRITE, both strobes are 0. IMEM_INPUT and WRITE_SELECT hold their last values.
- CHECK: on transfer, CKSUM_ERR=(chk^byte)!=0 (the XOR of all data bytes plus the checksum byte must equal 0x00), LOAD_DONE=1 for one cycle, go to IDLE.
- LOAD_START while BUSY is ignored.
- Latency: the first write occurs 1 cycle after the second byte transfers. Minimum load time is 3 cycles per word plus 1 for the checksum.
- Back-pressure: BYTE_VALID may drop at any time. The state simply waits.
- CKSUM_ERR does not undo writes. Software must reload.

Decomposition:
- Shared package (i281_loader_pkg):
  - state enum IDLE/HI_BYTE/LO_BYTE/WRITE/CHECK;
  - IMEM_WORDS=32 and BANK_WORDS=16 constants.
- One natural sub-module: imem_bank_decode. It takes addr[4:0] and a write pulse, and produces WRITE_SELECT, WRITE_ENABLE_LOW and WRITE_ENABLE_HIGH.
- The FSM, counters and checksum stay in the top module.

Test Plan:
1. Start base=0, length=2; stream 0x12,0x34,0xAB,0xCD, then checksum 0x12^0x34^0xAB^0xCD=0x40 -> low-bank writes 0x1234@0 and 0xABCD@1; LOAD_DONE pulses once; CKSUM_ERR=0; BUSY falls the cycle after.
2. Same stream with checksum 0x41 -> identical writes; LOAD_DONE pulses; CKSUM_ERR=1 and held until the next accepted start.
3. Start base=15, length=2 -> first write WRITE_ENABLE_LOW with select=15; second WRITE_ENABLE_HIGH with select=0.
4. Start base=31, length=2 -> writes at high bank select 15, then low bank select 0 (wrap-around).
5. LOAD_LENGTH=0 with LOAD_START -> BUSY stays 0, no strobes. LOAD_LENGTH=40 -> exactly 32 writes before CHECK.
6. Random BYTE_VALID gaps, extra LOAD_START pulses mid-load, and RESET_N=0 after the first write -> no byte lost or duplicated, starts ignored. Reset returns everything to IDLE with all outputs 0 and no LOAD_DONE pulse.
